// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardwired-zero r0, write bypass
// and a post-reset clear sequencer that sweeps every register to zero.
module regfile_mp #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 32,
  parameter int NRD     = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   adr_rs,
  output logic [NRD*XLEN-1:0] dout_rs,
  input  logic [AW-1:0]       adr_rd,
  input  logic [XLEN-1:0]     din_rd,
  input  logic                regwrite,
  output logic                busy
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [AW-1:0]   clr_idx;
  logic [AW-1:0]   clr_idx_nx;
  logic            clr_en;
  logic            wen;
  logic            wr_r0;
  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nx;
      clr_idx <= clr_idx_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_idx_nx = clr_idx;
    unique case (state)
      CLEAR: begin
        clr_idx_nx = clr_idx + 1'b1;
        if (clr_idx == AW'(DEPTH - 1))
          state_nx = RUN;
      end
      RUN: state_nx = RUN;
      default: state_nx = CLEAR;
    endcase
  end

  always_comb begin
    busy   = rst | (state == CLEAR);
    clr_en = ~rst & (state == CLEAR);
    wr_r0  = (ZERO_R0 != 0) && (adr_rd == '0);
    wen    = regwrite & ~busy & ~wr_r0;
  end

  // Sweep and normal writes never overlap: wen is gated by busy.
  always_ff @(posedge clk) begin
    if (clr_en)
      mem[clr_idx] <= '0;
    else if (wen)
      mem[adr_rd] <= din_rd;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            sel_zero;
    logic            sel_byp;
    logic            sel_mem;

    assign a = adr_rs[i*AW +: AW];

    always_comb begin
      sel_zero = busy | ((ZERO_R0 != 0) && (a == '0));
      sel_byp  = ~sel_zero & (BYPASS != 0) & wen & (adr_rd == a);
      sel_mem  = ~sel_zero & ~sel_byp;
      d        = '0;
      unique case (1'b1)
        sel_zero: d = '0;
        sel_byp:  d = din_rd;
        sel_mem:  d = mem[a];
        default:  d = '0;
      endcase
    end

    assign dout_rs[i*XLEN +: XLEN] = d;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: two instances (bypass+zero-r0,
// and plain) share stimulus; a monitor checks queued expectations.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NRD*AW-1:0]   adr_rs = '0;
  logic [AW-1:0]       adr_rd = '0;
  logic [XLEN-1:0]     din_rd = '0;
  logic                regwrite = 1'b0;
  logic [NRD*XLEN-1:0] dout_a;
  logic [NRD*XLEN-1:0] dout_b;
  logic                busy_a;
  logic                busy_b;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD),
    .BYPASS(1), .ZERO_R0(1)
  ) dut_a (
    .clk(clk), .rst(rst), .adr_rs(adr_rs),
    .dout_rs(dout_a), .adr_rd(adr_rd),
    .din_rd(din_rd), .regwrite(regwrite),
    .busy(busy_a)
  );

  regfile_mp #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD),
    .BYPASS(0), .ZERO_R0(0)
  ) dut_b (
    .clk(clk), .rst(rst), .adr_rs(adr_rs),
    .dout_rs(dout_b), .adr_rd(adr_rd),
    .din_rd(din_rd), .regwrite(regwrite),
    .busy(busy_b)
  );

  typedef struct {
    string       name;
    int          d;
    int          k;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // k=0: busy, k=1..NRD: read port k-1
  function automatic logic [31:0] probe(int d, int k);
    logic [NRD*XLEN-1:0] v;
    logic                b;
    v = (d != 0) ? dout_b : dout_a;
    b = (d != 0) ? busy_b : busy_a;
    if (k == 0) return {31'b0, b};
    return v[(k-1)*XLEN +: XLEN];
  endfunction

  initial begin
    exp_t        e;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        got = probe(e.d, e.k);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL %s dut%0d sel%0d got=%h exp=%h t=%0t",
                   e.name, e.d, e.k, got, e.exp, $time);
        end
      end
    end
  end

  task automatic exp2(string n, int k,
                      logic [31:0] ea, logic [31:0] eb);
    exp_t e;
    e.name = n; e.k = k;
    e.d = 0; e.exp = ea; q.push_back(e);
    e.d = 1; e.exp = eb; q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(int a0, int a1);
    adr_rs = {AW'(a1), AW'(a0)};
  endtask

  task automatic wr(logic we, int a, logic [31:0] v);
    regwrite = we;
    adr_rd   = AW'(a);
    din_rd   = v;
  endtask

  task automatic read_all_zero(string n);
    for (int a = 0; a < DEPTH; a++) begin
      rd(a, DEPTH - 1 - a);
      exp2(n, 1, 32'h0, 32'h0);
      exp2(n, 2, 32'h0, 32'h0);
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) begin
      step();
      rd(4, 4);
      exp2("rst_busy", 0, 32'h1, 32'h1);
      exp2("rst_dout", 1, 32'h0, 32'h0);
    end
    rst = 1'b0;

    // Sweep: busy for exactly DEPTH cycles; write at cycle 10 dropped
    for (int k = 0; k < DEPTH; k++) begin
      wr(k == 10, 3, 32'h0000_00FF);
      rd(3, 3);
      exp2("sweep_busy", 0, 32'h1, 32'h1);
      exp2("sweep_dout", 2, 32'h0, 32'h0);
      step();
    end
    wr(1'b0, 0, 32'h0);
    rd(3, 3);
    exp2("run_busy", 0, 32'h0, 32'h0);
    exp2("r3_dropped", 2, 32'h0, 32'h0);
    step();
    read_all_zero("clr_all");

    // Write r5 then read on both ports
    wr(1'b1, 5, 32'hDEAD_BEEF);
    rd(9, 9);
    exp2("r9_before", 1, 32'h0, 32'h0);
    step();
    wr(1'b0, 0, 32'h0);
    rd(5, 5);
    exp2("r5_p0", 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    exp2("r5_p1", 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    step();

    // r0: hardwired zero on dut_a only
    wr(1'b1, 0, 32'h1234_5678);
    rd(0, 5);
    exp2("r0_wcyc", 1, 32'h0, 32'h0);
    exp2("r5_keep", 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    step();
    wr(1'b0, 0, 32'h0);
    rd(0, 0);
    exp2("r0_p0", 1, 32'h0, 32'h1234_5678);
    exp2("r0_p1", 2, 32'h0, 32'h1234_5678);
    step();

    // Bypass: same-cycle forwarding on dut_a only
    wr(1'b1, 7, 32'h1111_1111);
    rd(1, 2);
    step();
    wr(1'b1, 7, 32'hA5A5_A5A5);
    rd(5, 7);
    exp2("byp_p1", 2, 32'hA5A5_A5A5, 32'h1111_1111);
    exp2("byp_p0", 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    step();
    wr(1'b0, 0, 32'h0);
    rd(7, 7);
    exp2("r7_p0", 1, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    exp2("r7_p1", 2, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    step();

    // Reset wins over a same-cycle write, then restart mid-sweep
    rst = 1'b1;
    wr(1'b1, 9, 32'hCAFE_F00D);
    rd(7, 9);
    exp2("rst2_busy", 0, 32'h1, 32'h1);
    exp2("rst2_dout", 1, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    wr(1'b0, 0, 32'h0);
    for (int k = 0; k < 20; k++) begin
      exp2("sw2_busy", 0, 32'h1, 32'h1);
      step();
    end
    rst = 1'b1;
    exp2("mid_rst_busy", 0, 32'h1, 32'h1);
    step();
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      exp2("sw3_busy", 0, 32'h1, 32'h1);
      step();
    end
    exp2("run2_busy", 0, 32'h0, 32'h0);
    step();
    read_all_zero("clr_all2");

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
